tx_sample_scheduler: RTL and testbench

- Controller in front of the TX channel (upsampler pair + upconversion CORDIC).
- Buffers baseband I/Q samples arriving on a valid/ready stream and releases exactly one sample per upsampler input strobe (ce_up).
- Owns the NCO phase accumulator that drives the channel's phase_input, including glitch-free retuning at sample boundaries.
- Sequences channel start-up (prime), steady-state run, and drain/stop.

---
 rtl/tx_sample_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_tx_sample_scheduler.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_sample_scheduler.sv
// tx_sample_scheduler
//   Front-end controller for the TX channel (upsampler pair + upconversion
//   CORDIC). It buffers baseband I/Q samples from a valid/ready stream and
//   releases one sample per ce_up strobe. It also owns the NCO phase
//   accumulator and sequences channel start-up, run and drain.
//
//   Build option: define TX_SCHED_UNDERRUN_CNT_EN to implement the saturating
//   underrun counter. When it is undefined, underrun_count is tied to 0. The
//   underrun pulse and the zero-fill behaviour are the same in both builds.
//
//   Input handshake: a sample transfers on a sys_clk edge where
//   s_valid && s_ready. s_ready depends only on FIFO occupancy, and on rst,
//   never on s_valid. The source must hold s_x/s_y stable while s_valid is
//   high and s_ready is low.

module tx_sample_scheduler #(
  parameter int IW          = 16,
  parameter int PW_I        = 19,
  parameter int AW          = 4,
  parameter int PRIME_LEVEL = 4,
  parameter int UCW         = 16
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [PW_I-1:0]        ftw_in,
  input  logic                   ftw_load,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [IW-1:0]   s_x,
  input  logic signed [IW-1:0]   s_y,
  input  logic                   ce_up,
  output logic signed [IW-1:0]   tx_x,
  output logic signed [IW-1:0]   tx_y,
  output logic [PW_I-1:0]        phase_out,
  output logic                   running,
  output logic [AW:0]            fifo_level,
  output logic [UCW-1:0]         underrun_count,
  output logic                   underrun
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] PRIME_L = (AW+1)'(PRIME_LEVEL);

  // Channel sequencing states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [2*IW-1:0]       r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_level;
  logic signed [IW-1:0]  r_tx_x;
  logic signed [IW-1:0]  r_tx_y;
  logic [PW_I-1:0]       r_phase;
  logic [PW_I-1:0]       r_ftw_shadow;
  logic [PW_I-1:0]       r_ftw_active;
  logic                  r_running;
  logic                  r_underrun;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  state_t                w_state_nxt;
  logic                  w_s_ready;
  logic                  w_push;
  logic                  w_active;
  logic                  w_nxt_active;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_zero_fill;
  logic                  w_underrun_evt;
  logic [2*IW-1:0]       w_rd_data;

  // Accept while not full; held low during the reset cycle.
  assign w_s_ready      = !rst && (r_level < DEPTH_L);
  assign w_push         = s_valid && w_s_ready;

  // Samples are only released while the channel is streaming.
  assign w_active       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_nxt_active   = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
  assign w_empty        = (r_level == '0);
  assign w_pop          = ce_up && w_active && !w_empty;

  // A strobe with nothing queued sends zeros. Only RUN treats it as a fault;
  // in DRAIN it means draining has finished.
  assign w_zero_fill    = ce_up && w_active && w_empty;
  assign w_underrun_evt = ce_up && (r_state == S_RUN) && w_empty;

  assign w_rd_data      = r_mem[r_rd_ptr];

  // Next-state selection for the start-up / run / drain sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_PRIME;
      end
      S_PRIME: begin
        if (!enable)                   w_state_nxt = S_IDLE;
        else if (r_level >= PRIME_L)   w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!enable) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // The drain completes on the first strobe that finds the FIFO empty.
        if (ce_up && w_empty) w_state_nxt = S_IDLE;
        else if (enable)      w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------

  // Storage array, written on each accepted sample (no reset needed)
  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {s_x, s_y};
  end

  // Pointers wrap naturally at 2**AW. Occupancy counts pushes minus pops.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer with registered channel outputs
  // ---------------------------------------------------------------------------

  // State, sample outputs, NCO phase, running and underrun pulse.
  // The phase and running are driven from the next state. This makes the
  // accumulator start on the same edge that enters RUN, and return to 0 on
  // the same edge that ends a drain.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tx_x     <= '0;
      r_tx_y     <= '0;
      r_phase    <= '0;
      r_running  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_running  <= w_nxt_active;
      r_underrun <= w_underrun_evt;

      if (w_pop) begin
        r_tx_x <= w_rd_data[2*IW-1:IW];
        r_tx_y <= w_rd_data[IW-1:0];
      end else if (w_zero_fill || !w_active) begin
        r_tx_x <= '0;
        r_tx_y <= '0;
      end

      if (w_nxt_active) r_phase <= r_phase + r_ftw_active;
      else              r_phase <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Frequency tuning word
  // ---------------------------------------------------------------------------

  // Shadow captures host writes. The active word updates only on strobe
  // cycles, so a retune lands on a sample boundary. A load that coincides
  // with the strobe passes straight through to the active word.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_ftw_shadow <= '0;
      r_ftw_active <= '0;
    end else begin
      if (ftw_load) r_ftw_shadow <= ftw_in;
      if (ce_up)    r_ftw_active <= ftw_load ? ftw_in : r_ftw_shadow;
    end
  end

  // ---------------------------------------------------------------------------
  // Underrun counter
  // ---------------------------------------------------------------------------
`ifdef TX_SCHED_UNDERRUN_CNT_EN
  logic [UCW-1:0] r_underrun_cnt;

  // Counts RUN-state underruns and holds at all-ones.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_underrun_cnt <= '0;
    end else if (w_underrun_evt && (r_underrun_cnt != '1)) begin
      r_underrun_cnt <= r_underrun_cnt + 1'b1;
    end
  end

  assign underrun_count = r_underrun_cnt;
`else
  assign underrun_count = '0;
`endif

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign s_ready    = w_s_ready;
  assign tx_x       = r_tx_x;
  assign tx_y       = r_tx_y;
  assign phase_out  = r_phase;
  assign running    = r_running;
  assign fifo_level = r_level;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_tx_sample_scheduler.sv
// Testbench for tx_sample_scheduler: a vector table, directed multi-cycle
// sequences and randomized traffic, all checked against a queue-based model.
// Honors TX_SCHED_UNDERRUN_CNT_EN in the same way as the design.

module tb_tx_sample_scheduler;

  localparam int IW    = 16;
  localparam int PW    = 19;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PRIME = 4;
  localparam int UCW   = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic                  rst, enable, ftw_load, s_valid, ce_up;
  logic                  s_ready, running, underrun;
  logic [PW-1:0]         ftw_in, phase_out;
  logic signed [IW-1:0]  s_x, s_y, tx_x, tx_y;
  logic [AW:0]           fifo_level;
  logic [UCW-1:0]        underrun_count;

  tx_sample_scheduler #(
    .IW(IW), .PW_I(PW), .AW(AW), .PRIME_LEVEL(PRIME), .UCW(UCW)
  ) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .enable         (enable),
    .ftw_in         (ftw_in),
    .ftw_load       (ftw_load),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_x            (s_x),
    .s_y            (s_y),
    .ce_up          (ce_up),
    .tx_x           (tx_x),
    .tx_y           (tx_y),
    .phase_out      (phase_out),
    .running        (running),
    .fifo_level     (fifo_level),
    .underrun_count (underrun_count),
    .underrun       (underrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------------------------------------------------------------------
  // Reference model: queue of samples plus a mode variable
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_PRIME, M_RUN, M_DRAIN} mode_t;
  mode_t           m_mode;
  logic [2*IW-1:0] exp_q[$];
  logic [IW-1:0]   m_tx_x, m_tx_y;
  logic [PW-1:0]   m_phase, m_shadow, m_active;
  logic            m_running, m_underrun;
  logic [UCW-1:0]  m_ucnt;

  task automatic model_step();
    int    lvl;
    mode_t nxt;
    logic  act;
    if (rst) begin
      exp_q.delete();
      m_mode = M_IDLE; m_tx_x = '0; m_tx_y = '0; m_phase = '0;
      m_shadow = '0; m_active = '0; m_running = 1'b0;
      m_underrun = 1'b0; m_ucnt = '0;
      return;
    end
    lvl = exp_q.size();
    act = (m_mode == M_RUN) || (m_mode == M_DRAIN);
    nxt = m_mode;
    m_underrun = 1'b0;
    case (m_mode)
      M_IDLE:  if (enable) nxt = M_PRIME;
      M_PRIME: if (!enable) nxt = M_IDLE; else if (lvl >= PRIME) nxt = M_RUN;
      M_RUN:   if (!enable) nxt = M_DRAIN;
      M_DRAIN: if (ce_up && lvl == 0) nxt = M_IDLE; else if (enable) nxt = M_RUN;
      default: nxt = M_IDLE;
    endcase
    if (act && ce_up) begin
      if (lvl > 0) begin
        {m_tx_x, m_tx_y} = exp_q.pop_front();
      end else begin
        m_tx_x = '0; m_tx_y = '0;
        if (m_mode == M_RUN) begin
          m_underrun = 1'b1;
`ifdef TX_SCHED_UNDERRUN_CNT_EN
          if (m_ucnt != '1) m_ucnt = m_ucnt + 1'b1;
`endif
        end
      end
    end else if (!act) begin
      m_tx_x = '0; m_tx_y = '0;
    end
    if (s_valid && lvl < DEPTH) exp_q.push_back({s_x, s_y});
    m_running = (nxt == M_RUN) || (nxt == M_DRAIN);
    m_phase   = m_running ? m_phase + m_active : '0;
    if (ce_up)    m_active = ftw_load ? ftw_in : m_shadow;
    if (ftw_load) m_shadow = ftw_in;
    m_mode = nxt;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic compare_all();
    check("tx_x",       {16'h0, tx_x}, {16'h0, m_tx_x});
    check("tx_y",       {16'h0, tx_y}, {16'h0, m_tx_y});
    check("phase_out",  32'(phase_out), 32'(m_phase));
    check("running",    32'(running), 32'(m_running));
    check("underrun",   32'(underrun), 32'(m_underrun));
    check("fifo_level", 32'(fifo_level), exp_q.size());
    check("urun_count", 32'(underrun_count), 32'(m_ucnt));
    check("s_ready",    32'(s_ready), 32'(!rst && (exp_q.size() < DEPTH)));
  endtask

  // One clock: step the model on the current inputs, then compare the
  // outputs at the falling edge.
  task automatic cyc();
    model_step();
    @(posedge sys_clk);
    @(negedge sys_clk);
    compare_all();
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic quiet();
    s_valid = 1'b0; ce_up = 1'b0; ftw_load = 1'b0; s_x = '0; s_y = '0;
  endtask

  task automatic do_reset();
    quiet();
    enable = 1'b0; ftw_in = '0; rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic push_s(input int v);
    s_valid = 1'b1; s_x = 16'(v); s_y = -16'(v);
    cyc();
    s_valid = 1'b0;
  endtask

  task automatic strobe();
    ce_up = 1'b1;
    cyc();
    ce_up = 1'b0;
  endtask

  task automatic load_ftw_now(input logic [PW-1:0] w);
    ftw_in = w; ftw_load = 1'b1; ce_up = 1'b1;
    cyc();
    ftw_load = 1'b0; ce_up = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rst, en, sv, ce;
    logic [15:0] sx;
    logic [15:0] e_tx;
    logic        e_run, e_ur;
    int          e_lvl;
  } vec_t;

  function automatic vec_t mk(input int r, input int en, input int sv, input int sx,
                              input int ce, input int etx, input int erun,
                              input int elvl, input int eur);
    vec_t v;
    v.rst = r[0]; v.en = en[0]; v.sv = sv[0]; v.sx = sx[15:0]; v.ce = ce[0];
    v.e_tx = etx[15:0]; v.e_run = erun[0]; v.e_lvl = elvl; v.e_ur = eur[0];
    return v;
  endfunction

  vec_t vt[17];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [PW-1:0] p;
    logic [15:0]   e16;
    int            exp_cnt;

    rst = 1'b1; enable = 1'b0; ftw_in = '0;
    quiet();

    // Fields:       rst en sv sx ce | tx run lvl ur
    vt[0]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0);
    vt[1]  = mk(0, 1, 1, 1, 0,   0, 0, 1, 0);
    vt[2]  = mk(0, 1, 1, 2, 0,   0, 0, 2, 0);
    vt[3]  = mk(0, 1, 1, 3, 0,   0, 0, 3, 0);
    vt[4]  = mk(0, 1, 0, 0, 1,   0, 0, 3, 0);  // strobe in PRIME ignored
    vt[5]  = mk(0, 1, 1, 4, 0,   0, 0, 4, 0);
    vt[6]  = mk(0, 1, 0, 0, 1,   0, 1, 4, 0);  // enters RUN, strobe ignored
    vt[7]  = mk(0, 1, 0, 0, 1,   1, 1, 3, 0);
    vt[8]  = mk(0, 1, 0, 0, 0,   1, 1, 3, 0);
    vt[9]  = mk(0, 1, 0, 0, 1,   2, 1, 2, 0);
    vt[10] = mk(0, 1, 1, 5, 1,   3, 1, 2, 0);  // push and pop together
    vt[11] = mk(0, 1, 0, 0, 1,   4, 1, 1, 0);
    vt[12] = mk(0, 1, 0, 0, 1,   5, 1, 0, 0);
    vt[13] = mk(0, 1, 0, 0, 1,   0, 1, 0, 1);  // underrun
    vt[14] = mk(0, 1, 0, 0, 0,   0, 1, 0, 0);
    vt[15] = mk(0, 1, 1, 6, 1,   0, 1, 1, 1);  // empty at strobe, push lands
    vt[16] = mk(0, 1, 0, 0, 1,   6, 1, 0, 0);

    for (int i = 0; i < 17; i++) begin
      rst = vt[i].rst; enable = vt[i].en; s_valid = vt[i].sv;
      s_x = vt[i].sx; s_y = -vt[i].sx; ce_up = vt[i].ce;
      cyc();
      check($sformatf("vec%0d_tx", i),  {16'h0, tx_x}, {16'h0, vt[i].e_tx});
      check($sformatf("vec%0d_run", i), 32'(running), 32'(vt[i].e_run));
      check($sformatf("vec%0d_lvl", i), 32'(fifo_level), vt[i].e_lvl);
      check($sformatf("vec%0d_ur", i),  32'(underrun), 32'(vt[i].e_ur));
    end
    quiet();

    // Ordering: eight samples, one strobe every 8 cycles
    do_reset();
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) push_s(k);
    check("ord_running", 32'(running), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      repeat (7) cyc();
      e16 = 16'(k - 1);
      check("ord_hold", {16'h0, tx_x}, {16'h0, e16});
      strobe();
      e16 = 16'(k);
      check("ord_tx_x", {16'h0, tx_x}, {16'h0, e16});
      e16 = -16'(k);
      check("ord_tx_y", {16'h0, tx_y}, {16'h0, e16});
      check("ord_no_urun", 32'(underrun), 32'd0);
    end

    // Underrun: one sample left, then three strobes
    do_reset();
    enable = 1'b1;
    for (int k = 100; k < 104; k++) push_s(k);
    cyc();
    repeat (3) strobe();
    cyc();
    check("ur_level1", 32'(fifo_level), 32'd1);
    strobe();
    check("ur_tx_s", {16'h0, tx_x}, 32'd103);
    check("ur_p0", 32'(underrun), 32'd0);
    cyc();
    strobe();
    check("ur_tx_0a", {16'h0, tx_x}, 32'd0);
    check("ur_p1", 32'(underrun), 32'd1);
    cyc();
    check("ur_p1_end", 32'(underrun), 32'd0);
    strobe();
    check("ur_tx_0b", {16'h0, tx_x}, 32'd0);
    check("ur_p2", 32'(underrun), 32'd1);
`ifdef TX_SCHED_UNDERRUN_CNT_EN
    exp_cnt = 2;
`else
    exp_cnt = 0;
`endif
    check("ur_count", 32'(underrun_count), exp_cnt);

    // Retune: a new word takes effect only after the next strobe
    do_reset();
    load_ftw_now(19'h00100);
    enable = 1'b1;
    for (int k = 0; k < 4; k++) push_s(k + 10);
    cyc();
    check("rt_running", 32'(running), 32'd1);
    p = phase_out; cyc();
    check("rt_d100a", 32'(phase_out), 32'(p + 19'h100));
    ftw_in = 19'h00200; ftw_load = 1'b1;
    p = phase_out; cyc(); ftw_load = 1'b0;
    check("rt_d100b", 32'(phase_out), 32'(p + 19'h100));
    p = phase_out; cyc();
    check("rt_d100c", 32'(phase_out), 32'(p + 19'h100));
    p = phase_out; strobe();
    check("rt_d100_ce", 32'(phase_out), 32'(p + 19'h100));
    p = phase_out; cyc();
    check("rt_d200a", 32'(phase_out), 32'(p + 19'h200));
    p = phase_out; cyc();
    check("rt_d200b", 32'(phase_out), 32'(p + 19'h200));

    // Wrap: phase 0x7FF00 plus 0x200 gives 0x00100
    do_reset();
    load_ftw_now(19'h7FF00);
    ftw_in = 19'h00200; ftw_load = 1'b1; enable = 1'b1;
    cyc();
    ftw_load = 1'b0;
    for (int k = 0; k < 4; k++) push_s(k + 20);
    strobe();
    check("wr_phase0", 32'(phase_out), 32'h7FF00);
    check("wr_no_pop", 32'(fifo_level), 32'd4);
    check("wr_tx0", {16'h0, tx_x}, 32'd0);
    cyc();
    check("wr_phase1", 32'(phase_out), 32'h00100);

    // Drain: five queued samples come out, the sixth strobe returns to IDLE
    do_reset();
    load_ftw_now(19'h00123);
    enable = 1'b1;
    for (int k = 0; k < 5; k++) push_s(200 + k);
    check("dr_run", 32'(running), 32'd1);
    check("dr_lvl", 32'(fifo_level), 32'd5);
    enable = 1'b0;
    cyc();
    for (int k = 0; k < 5; k++) begin
      strobe();
      check("dr_tx", {16'h0, tx_x}, 32'(200 + k));
      check("dr_running", 32'(running), 32'd1);
      cyc();
    end
    strobe();
    check("dr_idle", 32'(running), 32'd0);
    check("dr_tx0", {16'h0, tx_x}, 32'd0);
    check("dr_phase0", 32'(phase_out), 32'd0);
    check("dr_no_urun", 32'(underrun), 32'd0);
    check("dr_count", 32'(underrun_count), 32'd0);

    // Full: the 17th sample stalls. Then reset while in RUN.
    do_reset();
    load_ftw_now(19'h00055);
    s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_x = 16'(i + 1); s_y = -16'(i + 1);
      cyc();
    end
    check("full_lvl", 32'(fifo_level), 32'd16);
    check("full_rdy", 32'(s_ready), 32'd0);
    s_x = 16'h0BAD; s_y = 16'h0BAD;
    cyc();
    check("full_stall_lvl", 32'(fifo_level), 32'd16);
    check("full_stall_rdy", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    enable = 1'b1;
    repeat (2) cyc();
    strobe();
    check("full_first", {16'h0, tx_x}, 32'd1);
    check("full_after_pop", 32'(s_ready), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();
    check("rst_tx", {16'h0, tx_x}, 32'd0);
    check("rst_phase", 32'(phase_out), 32'd0);
    check("rst_run", 32'(running), 32'd0);
    check("rst_lvl", 32'(fifo_level), 32'd0);
    check("rst_rdy", 32'(s_ready), 32'd0);
    rst = 1'b0;

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      s_valid  = ($urandom_range(0, 9) < ((n < 1500) ? 6 : 2));
      s_x      = 16'($urandom);
      s_y      = 16'($urandom);
      ce_up    = ($urandom_range(0, 9) < ((n < 1500) ? 2 : 5));
      ftw_load = ($urandom_range(0, 19) == 0);
      ftw_in   = PW'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
